// File: rtl/range_level_generator.sv
// Converts a 2-bit range class into a 7-bit level that ramps, one prescaled step at a time, to the class's representative value.
// Optional RANGE_LEVEL_GEN_FAST_STEP_EN selects 4-unit steps instead of 1.
module range_level_generator #(
    parameter int PRESCALE   = 4,
    parameter int INIT_VALUE = 0,
    parameter int TARGET0    = 16,
    parameter int TARGET1    = 48,
    parameter int TARGET2    = 80,
    parameter int TARGET3    = 112
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] class_in,
    input  logic       class_valid,
    output logic       class_ready,
    output logic [6:0] number,
    output logic       busy,
    output logic       done
);

`ifdef RANGE_LEVEL_GEN_FAST_STEP_EN
    localparam logic [6:0] STEP = 7'd4;
`else
    localparam logic [6:0] STEP = 7'd1;
`endif

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);
    localparam logic [6:0] INIT    = 7'(INIT_VALUE);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t     state;
    logic [7:0] prescaler;
    logic [6:0] target;
    logic [6:0] sel_target;
    logic [6:0] next_number;

    always_comb begin
        case (class_in)
            2'd0:    sel_target = 7'(TARGET0);
            2'd1:    sel_target = 7'(TARGET1);
            2'd2:    sel_target = 7'(TARGET2);
            default: sel_target = 7'(TARGET3);
        endcase
    end

    // Move one step toward target; a remaining gap smaller than STEP snaps exactly,
    // so the subtraction never wraps past 0 or 127.
    always_comb begin
        next_number = number;
        if (target > number)
            next_number = ((target - number) < STEP) ? target : number + STEP;
        else if (target < number)
            next_number = ((number - target) < STEP) ? target : number - STEP;
    end

    assign class_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            number    <= INIT;
            target    <= INIT;
            prescaler <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (class_valid) begin
                        target    <= sel_target;
                        prescaler <= '0;
                        if (sel_target == number) begin
                            done <= 1'b1;
                        end else begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (prescaler == PS_LAST) begin
                        prescaler <= '0;
                        number    <= next_number;
                        if (next_number == target) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
